// File: rtl/prescale_counter_bank_pkg.sv
// Shared definitions for the prescaled counter bank: counting modes and the
// channel-select width helper.
package prescale_counter_bank_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Select width is clog2 of the channel count, never narrower than one bit.
  function automatic int selWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prescale_counter_ch.sv
// One prescaled counter channel: prescaler, divisor, mode, count, sticky
// overflow and a registered tick for every advance attempt.
module prescale_counter_ch
  import prescale_counter_bank_pkg::*;
#(
  parameter int CW      = 64,
  parameter int PW      = 8,
  parameter int DIV_RST = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_count,
  input  logic          i_clr,
  input  logic          i_cfg,
  input  logic [PW-1:0] i_cfg_div,
  input  logic          i_cfg_sat,
  output logic [CW-1:0] o_count,
  output logic          o_tick,
  output logic          o_ovf
);

  localparam logic [PW-1:0] DIV_INIT  = PW'(DIV_RST);
  localparam logic [CW-1:0] COUNT_MAX = '1;

  logic [PW-1:0] r_pre;
  logic [PW-1:0] r_div;
  mode_e         r_mode;
  logic [CW-1:0] r_count;
  logic          r_tick;
  logic          r_ovf;

  logic [PW-1:0] w_last;
  logic          w_roll;

  // A divisor of zero behaves as one, so the last prescaler step is then zero.
  assign w_last = (r_div == '0) ? '0 : (r_div - PW'(1));
  assign w_roll = (r_pre >= w_last);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pre   <= '0;
      r_div   <= DIV_INIT;
      r_mode  <= MODE_WRAP;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_clr) begin
        r_pre   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (i_cfg) begin
        r_div  <= i_cfg_div;
        r_mode <= mode_e'(i_cfg_sat);
        r_pre  <= '0;
      end else if (i_count) begin
        if (w_roll) begin
          r_pre  <= '0;
          r_tick <= 1'b1;
          // At full scale the attempt always flags overflow; only wrap mode moves.
          if (r_count == COUNT_MAX) begin
            r_ovf <= 1'b1;
            if (r_mode == MODE_WRAP) begin
              r_count <= '0;
            end
          end else begin
            r_count <= r_count + CW'(1);
          end
        end else begin
          r_pre <= r_pre + PW'(1);
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_tick  = r_tick;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/prescale_counter_bank.sv
// Bank of independently configured prescaled counters; this level only decodes
// the channel selects and fans them out to the per-channel instances.
module prescale_counter_bank
  import prescale_counter_bank_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CW      = 64,
  parameter int PW      = 8,
  parameter int DIV_RST = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_en,
  input  logic [selWidth(NCH)-1:0] i_slt,
  input  logic                     i_clr,
  input  logic                     i_cfg_we,
  input  logic [selWidth(NCH)-1:0] i_cfg_ch,
  input  logic [PW-1:0]            i_cfg_div,
  input  logic                     i_cfg_sat,
  output logic [NCH*CW-1:0]        o_count,
  output logic [NCH-1:0]           o_tick,
  output logic [NCH-1:0]           o_ovf
);

  localparam int SW = selWidth(NCH);

  for (genvar g = 0; g < NCH; g++) begin : gen_ch
    logic w_sel;
    logic w_cfgHit;
    logic w_clr;
    logic w_cnt;

    // Selects beyond the last channel match no instance and are ignored.
    assign w_sel    = (i_slt == SW'(g));
    assign w_cfgHit = i_cfg_we && (i_cfg_ch == SW'(g));
    assign w_clr    = i_clr && w_sel;
    assign w_cnt    = i_en && w_sel && !i_clr && !w_cfgHit;

    prescale_counter_ch #(
      .CW      (CW),
      .PW      (PW),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_count   (w_cnt),
      .i_clr     (w_clr),
      .i_cfg     (w_cfgHit),
      .i_cfg_div (i_cfg_div),
      .i_cfg_sat (i_cfg_sat),
      .o_count   (o_count[g*CW +: CW]),
      .o_tick    (o_tick[g]),
      .o_ovf     (o_ovf[g])
    );
  end

endmodule

// File: tb/tb_prescale_counter_bank.sv
// Scoreboard bench for prescale_counter_bank: directed scenarios plus random
// traffic, predicted by a per-channel arithmetic model.
module tb_prescale_counter_bank;

  localparam int NCH     = 5;
  localparam int CW      = 4;
  localparam int PW      = 4;
  localparam int DIV_RST = 1;
  localparam int SW      = 3;
  localparam int CMAX    = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [SW-1:0]     slt;
  logic              clr;
  logic              cfgWe;
  logic [SW-1:0]     cfgCh;
  logic [PW-1:0]     cfgDiv;
  logic              cfgSat;
  logic [NCH*CW-1:0] count;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    ovf;

  typedef struct {
    logic [NCH*CW-1:0] count;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    ovf;
  } exp_t;

  exp_t expQ[$];

  int mCount[NCH];
  int mPre[NCH];
  int mDiv[NCH];
  int mSat[NCH];
  int mOvf[NCH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prescale_counter_bank #(
    .NCH     (NCH),
    .CW      (CW),
    .PW      (PW),
    .DIV_RST (DIV_RST)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_en      (en),
    .i_slt     (slt),
    .i_clr     (clr),
    .i_cfg_we  (cfgWe),
    .i_cfg_ch  (cfgCh),
    .i_cfg_div (cfgDiv),
    .i_cfg_sat (cfgSat),
    .o_count   (count),
    .o_tick    (tick),
    .o_ovf     (ovf)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one clock of the bank, applied to every channel.
  task automatic modelStep(input logic r, input logic e, input logic c, input int s,
                           input logic w, input int ch, input int d, input logic sat);
    exp_t x;
    x.tick = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        mCount[i] = 0; mPre[i] = 0; mDiv[i] = DIV_RST; mSat[i] = 0; mOvf[i] = 0;
      end else if (c && s == i) begin
        mCount[i] = 0; mPre[i] = 0; mOvf[i] = 0;
      end else if (w && ch == i) begin
        mDiv[i] = d; mSat[i] = int'(sat); mPre[i] = 0;
      end else if (e && s == i) begin
        if (mPre[i] + 1 >= ((mDiv[i] == 0) ? 1 : mDiv[i])) begin
          mPre[i] = 0;
          x.tick[i] = 1'b1;
          if (mCount[i] == CMAX) begin
            mOvf[i] = 1;
            if (mSat[i] == 0) mCount[i] = 0;
          end else begin
            mCount[i] = mCount[i] + 1;
          end
        end else begin
          mPre[i] = mPre[i] + 1;
        end
      end
      x.count[i*CW +: CW] = CW'(mCount[i]);
      x.ovf[i] = (mOvf[i] != 0);
    end
    expQ.push_back(x);
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic c, input int s,
                               input logic w, input int ch, input int d, input logic sat);
    @(negedge clk);
    reset = r; en = e; clr = c; slt = SW'(s);
    cfgWe = w; cfgCh = SW'(ch); cfgDiv = PW'(d); cfgSat = sat;
    modelStep(r, e, c, s, w, ch, d, sat);
  endtask

  task automatic countOn(input int ch, input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, 0, ch, 0, 0, 0, 0);
  endtask

  // Constant-valued check of one channel just after the pending edge.
  task automatic expectChannel(input string name, input int ch, input int cnt, input logic ov);
    logic [CW-1:0] slice;
    @(posedge clk);
    #2;
    slice = count[ch*CW +: CW];
    checkOutput({name, "_count"}, 64'(slice), 64'(cnt));
    checkOutput({name, "_ovf"}, 64'(ovf[ch]), 64'(ov));
  endtask

  // Monitor: every cycle with a pending prediction is compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("mon_count", 64'(count), 64'(e.count));
        checkOutput("mon_tick", 64'(tick), 64'(e.tick));
        checkOutput("mon_ovf", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_tick", 64'(tick), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);

    countOn(0, 10);
    expectChannel("ch0_div1", 0, 10, 1'b0);
    checkOutput("ch0_others", 64'(count[NCH*CW-1:CW]), 64'd0);

    applyStimulus(0, 0, 0, 0, 1, 1, 4, 0);
    countOn(1, 12);
    expectChannel("ch1_div4", 1, 3, 1'b0);

    applyStimulus(0, 0, 0, 0, 1, 2, 1, 0);
    countOn(2, 16);
    expectChannel("ch2_wrap", 2, 0, 1'b1);
    applyStimulus(0, 0, 1, 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 2, 1, 1);
    countOn(2, 16);
    expectChannel("ch2_sat", 2, 15, 1'b1);

    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    countOn(1, 3);
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0);
    expectChannel("ch1_clr_en", 1, 0, 1'b0);
    checkOutput("ch1_clr_notick", 64'(tick[1]), 64'd0);
    countOn(1, 4);
    expectChannel("ch1_after_clr", 1, 1, 1'b0);

    applyStimulus(0, 0, 0, 0, 1, 3, 5, 0);
    countOn(3, 2);
    applyStimulus(0, 1, 0, 3, 1, 3, 2, 0);
    expectChannel("ch3_cfg_en", 3, 0, 1'b0);
    countOn(3, 2);
    expectChannel("ch3_div2", 3, 1, 1'b0);

    applyStimulus(0, 0, 1, 0, 1, 4, 3, 1);
    expectChannel("clr_ch0_cfg_ch4", 0, 0, 1'b0);
    countOn(4, 3);
    expectChannel("ch4_div3", 4, 1, 1'b0);

    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    checkOutput("midrst_count", 64'(count), 64'd0);
    checkOutput("midrst_ovf", 64'(ovf), 64'd0);
    checkOutput("midrst_tick", 64'(tick), 64'd0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 5 + (k % 3), 1, 5 + ((k + 1) % 3), 7, 1);
    @(posedge clk); #2;
    checkOutput("oob_count", 64'(count), 64'd0);
    countOn(0, 1);
    expectChannel("div_rst", 0, 1, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 39) == 0), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 19) == 0), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    end

    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
    #2;
    checkOutput("drain", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescale_counter_bank.md
PRESCALE_COUNTER_BANK -- requirements
Module: prescale_counter_bank

Interface
REQ-001 Parameter NCH, default 4: number of counter channels, 2..16.
REQ-002 Parameter CW, default 64: count width per channel.
REQ-003 Parameter PW, default 8: prescale divisor width.
REQ-004 Parameter DIV_RST, default 1: divisor loaded into every channel at reset, 1..2^PW-1.
REQ-005 Clk  in  1  sole clock, all state updates on rising edge.
REQ-006 Reset  in  1  one clock; reset is synchronous and active-high.
REQ-007 En  in  1  count enable for the selected channel.
REQ-008 Slt  in  SW=max(1,clog2(NCH))  channel select for En and Clr.
REQ-009 Clr  in  1  synchronous clear of the selected channel.
REQ-010 Cfg_we  in  1  divisor/mode write strobe.
REQ-011 Cfg_ch  in  SW  channel addressed by the config write.
REQ-012 Cfg_div  in  PW  new divisor value.
REQ-013 Cfg_sat  in  1  new mode: 1 = saturate, 0 = wrap.
REQ-014 Count  out  NCH*CW  packed counts, channel i at bits [i*CW +: CW], registered.
REQ-015 Tick  out  NCH  one-cycle pulse, registered, high in the cycle after channel i's count advanced or attempted to advance.
REQ-016 Ovf  out  NCH  sticky overflow flag per channel, registered.

Function
REQ-017 Each channel SHALL hold count C[CW], prescaler P[PW], divisor D[PW] and mode bit S.
REQ-018 Effective divisor SHALL be D, with D=0 treated as 1.
REQ-019 A cycle SHALL be "counted" for channel i when En=1, Slt=i, Clr=0, and no config write targets i; no other channel changes in that cycle.
REQ-020 On a counted cycle with P < D_eff-1, the channel SHALL set P <= P+1 and leave C unchanged.
REQ-021 On a counted cycle with P = D_eff-1, the channel SHALL set P <= 0 and attempt C+1; Tick[i] SHALL be 1 in the following cycle.
REQ-022 Wrap mode (S=0): attempt at C = 2^CW-1 SHALL give C <= 0 and Ovf[i] <= 1.
REQ-023 Saturate mode (S=1): attempt at C = 2^CW-1 SHALL hold C and set Ovf[i] <= 1; Tick still pulses.
REQ-024 Ovf[i] SHALL stay 1 until Reset or Clr of channel i.
REQ-025 Clr=1 with Slt=i SHALL set C, P and Ovf[i] to 0 next cycle, regardless of En.
REQ-026 Cfg_we=1 with Cfg_ch=i SHALL load D <= Cfg_div and S <= Cfg_sat, and clear P; C and Ovf are untouched.
REQ-027 Same-cycle priority per channel: Reset > Clr > config write > count.
REQ-028 Clr on channel a and config write on channel b≠a in the same cycle SHALL both take effect.
REQ-029 Slt or Cfg_ch >= NCH SHALL have no effect.
REQ-030 Latency: a counted cycle SHALL be visible on Count one clock later; no combinational path from inputs to outputs.

Reset
REQ-031 On Reset=1 at a rising edge: all C=0, all P=0, all D=DIV_RST, all S=0, Count=0, Tick=0, Ovf=0.
REQ-032 Reset asserted mid-prescale SHALL discard partial prescaler progress; no Tick follows.
REQ-033 Behaviour at power-up before the first Reset is undefined; the bench SHALL apply Reset first.

Structure
REQ-034 Shared package SHALL hold the mode encodings (MODE_WRAP=0, MODE_SAT=1) and the select-width function.
REQ-035 One sub-module, prescale_counter_ch (single channel: P, D, S, C, Ovf, Tick), SHALL be instantiated NCH times via generate; the top performs select decoding only.

Verification
REQ-036 Reset; En=1, Slt=0 for 10 cycles -> Count[0]=10, other channels 0, Tick[0] high each cycle.
REQ-037 Cfg ch1 div=4 wrap; En=1, Slt=1 for 12 cycles -> Count[1]=3, Tick[1] pulses after cycles 4, 8, 12.
REQ-038 CW=4, ch2 div=1, S=0; 16 counted cycles -> Count[2]=0, Ovf[2]=1; repeat with S=1 -> Count[2]=15, Ovf[2]=1.
REQ-039 ch1 div=4, 3 counted cycles, then Clr+En on ch1 -> C=0, P=0, no Tick; 4 more counted cycles -> Count[1]=1.
REQ-040 ch3 div=5, 2 counted cycles, then Cfg_we to ch3 div=2 in the same cycle as En -> P=0, no count; 2 more counted cycles -> Count[3]=1.
REQ-041 Reset mid-run with nonzero counts and Ovf set -> all outputs 0 next cycle, D=DIV_RST, Slt=NCH stimulus -> no change.
